// File: rtl/de0_nano_system_i2c_line_phy_if.sv
// Avalon-MM slave bus for the I2C line PHY status registers.
// Zero wait states: readdata is combinational from address.
interface de0_nano_system_i2c_line_phy_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport slave  (input  address, chipselect, write_n, writedata, output readdata);
    modport master (output address, chipselect, write_n, writedata, input  readdata);
endinterface

// File: rtl/de0_nano_system_i2c_line_phy.sv
// Open-drain I2C pad stage: PIO levels to pad enables, synchronised/glitch-filtered lines,
// START/STOP detection and slave clock-stretch measurement with a sticky timeout.
module de0_nano_system_i2c_line_phy #(
    parameter int FILT_CYCLES     = 4,
    parameter int STRETCH_TIMEOUT = 50000,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic scl_req,
    input  logic sda_req,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_oe,
    output logic sda_oe,
    de0_nano_system_i2c_line_phy_if.slave avs
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_STRETCH} state_t;

    localparam logic [4:0]       WAIT_CYC = 5'(2 + FILT_CYCLES);
    localparam logic [CNT_W-1:0] TO_MAX   = CNT_W'(STRETCH_TIMEOUT);
    localparam logic [CNT_W-1:0] TO_M1    = CNT_W'(STRETCH_TIMEOUT - 1);

    // Index 0 = SCL, index 1 = SDA throughout.
    logic [1:0] pad_in;
    logic [1:0] filt_cur;
    logic [1:0] filt_nxt;

    assign pad_in = {sda_in, scl_in};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_line
            logic       s1_q, s1_d, s2_q, s2_d, f_q, f_d;
            logic [3:0] c_q, c_d;

            always_comb begin
                s1_d = pad_in[gi];
                s2_d = s1_q;
                f_d  = f_q;
                c_d  = '0;
                if (s2_q != f_q) begin
                    if (c_q + 4'd1 == FILT_CYCLES[3:0]) begin
                        f_d = s2_q;
                    end else begin
                        c_d = c_q + 4'd1;
                    end
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    s1_q <= 1'b1;
                    s2_q <= 1'b1;
                    f_q  <= 1'b1;
                    c_q  <= '0;
                end else begin
                    s1_q <= s1_d;
                    s2_q <= s2_d;
                    f_q  <= f_d;
                    c_q  <= c_d;
                end
            end

            assign filt_cur[gi] = f_q;
            assign filt_nxt[gi] = f_d;
        end
    endgenerate

    state_t           state_q, state_d;
    logic [4:0]       wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] stretch_cnt_q, stretch_cnt_d;
    logic [CNT_W-1:0] last_stretch_q, last_stretch_d;
    logic             scl_oe_q, scl_oe_d, sda_oe_q, sda_oe_d;
    logic             timeout_q, timeout_d, start_q, start_d, stop_q, stop_d, busy_q, busy_d;
    logic             wr_status, sda_fall, sda_rise, stretching;
    logic             wr_unused;

    assign wr_unused  = ^{avs.writedata[31:4], avs.writedata[0]};
    assign wr_status  = avs.chipselect & ~avs.write_n & (avs.address == 2'd1);
    assign sda_fall   = filt_cur[1] & ~filt_nxt[1] & filt_cur[0];
    assign sda_rise   = ~filt_cur[1] & filt_nxt[1] & filt_cur[0];
    assign stretching = (state_q == ST_STRETCH);

    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        stretch_cnt_d  = stretch_cnt_q;
        last_stretch_d = last_stretch_q;
        timeout_d      = timeout_q;
        start_d        = start_q;
        stop_d         = stop_q;
        busy_d         = busy_q;
        scl_oe_d       = ~scl_req;
        sda_oe_d       = ~sda_req;

        // Clears first so that a same-cycle set event below takes precedence.
        if (wr_status) begin
            if (avs.writedata[1]) timeout_d = 1'b0;
            if (avs.writedata[2]) start_d   = 1'b0;
            if (avs.writedata[3]) stop_d    = 1'b0;
        end
        if (sda_fall) begin
            start_d = 1'b1;
            busy_d  = 1'b1;
        end
        if (sda_rise) begin
            stop_d = 1'b1;
            busy_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (scl_oe_q && !scl_oe_d) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = '0;
                end
            end
            ST_WAIT: begin
                if (scl_oe_q) begin
                    state_d = ST_IDLE;
                end else if (wait_cnt_q == WAIT_CYC) begin
                    state_d = filt_cur[0] ? ST_IDLE : ST_STRETCH;
                end else begin
                    wait_cnt_d = wait_cnt_q + 5'd1;
                end
            end
            ST_STRETCH: begin
                if (scl_oe_q) begin
                    state_d       = ST_IDLE;
                    stretch_cnt_d = '0;
                end else if (filt_cur[0]) begin
                    state_d        = ST_IDLE;
                    last_stretch_d = stretch_cnt_q;
                    stretch_cnt_d  = '0;
                end else if (stretch_cnt_q != TO_MAX) begin
                    stretch_cnt_d = stretch_cnt_q + 1'b1;
                    // One-shot set on reaching the limit, so software can clear it mid-stretch.
                    if (stretch_cnt_q == TO_M1) timeout_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            wait_cnt_q     <= '0;
            stretch_cnt_q  <= '0;
            last_stretch_q <= '0;
            scl_oe_q       <= 1'b0;
            sda_oe_q       <= 1'b0;
            timeout_q      <= 1'b0;
            start_q        <= 1'b0;
            stop_q         <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            stretch_cnt_q  <= stretch_cnt_d;
            last_stretch_q <= last_stretch_d;
            scl_oe_q       <= scl_oe_d;
            sda_oe_q       <= sda_oe_d;
            timeout_q      <= timeout_d;
            start_q        <= start_d;
            stop_q         <= stop_d;
            busy_q         <= busy_d;
        end
    end

    assign scl_oe = scl_oe_q;
    assign sda_oe = sda_oe_q;

    always_comb begin
        avs.readdata = '0;
        case (avs.address)
            2'd0:    avs.readdata[3:0]       = {sda_oe_q, scl_oe_q, filt_cur[1], filt_cur[0]};
            2'd1:    avs.readdata[4:0]       = {busy_q, stop_q, start_q, timeout_q, stretching};
            2'd2:    avs.readdata[CNT_W-1:0] = last_stretch_q;
            default: avs.readdata            = '0;
        endcase
    end

endmodule

// File: tb/tb_de0_nano_system_i2c_line_phy.sv
// Directed + randomized bench for the I2C line PHY; open-drain pads modelled with pull-ups.
module tb_de0_nano_system_i2c_line_phy;
    localparam int FILT = 4;
    localparam int TO   = 250;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic scl_req = 1'b1, sda_req = 1'b1;
    logic slave_hold = 1'b0, sda_low = 1'b0;
    logic scl_in, sda_in, scl_oe, sda_oe;
    int   checks = 0, errors = 0;

    de0_nano_system_i2c_line_phy_if avs_if ();

    de0_nano_system_i2c_line_phy #(.FILT_CYCLES(FILT), .STRETCH_TIMEOUT(TO), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .scl_req(scl_req), .sda_req(sda_req),
        .scl_in(scl_in), .sda_in(sda_in), .scl_oe(scl_oe), .sda_oe(sda_oe), .avs(avs_if)
    );

    // Wired-AND bus with pull-ups: either side pulling low wins.
    assign scl_in = ~(scl_oe | slave_hold);
    assign sda_in = ~(sda_oe | sda_low);

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        avs_if.address    = a;
        avs_if.chipselect = 1'b1;
        #1;
        d = avs_if.readdata;
        avs_if.chipselect = 1'b0;
        $display("rd addr=%0d data=0x%08h", a, d);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        avs_if.address    = a;
        avs_if.writedata  = d;
        avs_if.chipselect = 1'b1;
        avs_if.write_n    = 1'b0;
        @(negedge clk);
        avs_if.chipselect = 1'b0;
        avs_if.write_n    = 1'b1;
        $display("wr addr=%0d data=0x%08h", a, d);
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] last;
        int L, H, exp_f;

        avs_if.address = '0; avs_if.chipselect = 1'b0; avs_if.write_n = 1'b1; avs_if.writedata = '0;

        // Reset state, both during and after reset
        cyc(3);
        rd(0, d); check("rst_addr0", d, 32'h3);
        rd(1, d); check("rst_addr1", d, 32'h0);
        rd(2, d); check("rst_addr2", d, 32'h0);
        check("rst_scl_oe", scl_oe, 1'b0);
        reset_n = 1'b1;
        cyc(2);
        rd(0, d); check("post_rst_addr0", d, 32'h3);

        // Output-enable is registered: one cycle latency, inverted
        sda_req = 1'b0; #1;
        check("sda_oe_before_edge", sda_oe, 1'b0);
        cyc(1); check("sda_oe_after_edge", sda_oe, 1'b1);
        sda_req = 1'b1;
        cyc(1); check("sda_oe_release", sda_oe, 1'b0);

        // Glitch filter: SDA low pulses of length L with SCL high
        for (int i = 0; i < 8; i++) begin
            L = (i == 0) ? 3 : (i == 1) ? FILT : int'($urandom_range(1, 9));
            wr(1, 32'hE);
            sda_low = 1'b1;
            for (int k = 1; k <= L + FILT + 4; k++) begin
                @(negedge clk);
                avs_if.address = 2'd0; #1;
                d = avs_if.readdata;
                exp_f = (L >= FILT && k >= 2 + FILT && k <= L + 1 + FILT) ? 0 : 1;
                check($sformatf("filt_sda L=%0d k=%0d", L, k), d[1], exp_f[0]);
                check($sformatf("filt_scl L=%0d k=%0d", L, k), d[0], 1'b1);
                if (k == L) sda_low = 1'b0;
            end
            rd(1, d);
            check($sformatf("pulse_flags L=%0d", L), d, (L >= FILT) ? 32'h0C : 32'h0);
        end

        // START then STOP
        wr(1, 32'hE);
        sda_low = 1'b1; cyc(10);
        rd(1, d); check("start_flags", d, 32'h14);
        sda_low = 1'b0; cyc(10);
        rd(1, d); check("stop_flags", d, 32'h0C);

        // W1C of start_seen on the exact cycle a new START is detected
        sda_low = 1'b1;
        cyc(5);
        wr(1, 32'h4);
        rd(0, d); check("w1c_race_sda_f", d[1], 1'b0);
        rd(1, d); check("w1c_race_start", d[2], 1'b1);
        wr(1, 32'h4);
        rd(1, d); check("w1c_clear_start", d[2], 1'b0);
        sda_low = 1'b0; cyc(10);

        // Clock stretch of random length
        wr(1, 32'hE);
        scl_req = 1'b0; cyc(1);
        check("scl_oe_drive", scl_oe, 1'b1);
        cyc(10);
        rd(0, d); check("scl_f_low", d[0], 1'b0);
        H = int'($urandom_range(150, 220));
        scl_req = 1'b1; slave_hold = 1'b1;
        for (int k = 1; k <= H; k++) begin
            @(negedge clk);
            if (k == H / 2) begin
                rd(1, d); check("stretching_mid", d, 32'h1);
            end
        end
        slave_hold = 1'b0;
        cyc(20);
        rd(2, d);
        checks++;
        assert (d >= 32'(H - 8) && d <= 32'(H + 8)) else begin
            errors++;
            $error("FAIL stretch_len observed=%0d expected=%0d..%0d", d, H - 8, H + 8);
        end
        last = d;
        rd(1, d); check("after_stretch_flags", d, 32'h0);

        // Release with no stretch leaves last_stretch untouched
        scl_req = 1'b0; cyc(12);
        scl_req = 1'b1; cyc(20);
        rd(2, d); check("no_stretch_keep", d, last);
        rd(1, d); check("no_stretch_flags", d, 32'h0);

        // Timeout and saturation
        scl_req = 1'b0; cyc(12);
        scl_req = 1'b1; slave_hold = 1'b1; cyc(300);
        rd(1, d); check("timeout_set", d, 32'h3);
        cyc(200);
        slave_hold = 1'b0; cyc(20);
        rd(2, d); check("stretch_saturated", d, TO);
        rd(1, d); check("timeout_sticky", d, 32'h2);
        wr(1, 32'h2);
        rd(1, d); check("timeout_w1c", d, 32'h0);

        // Master re-drives SCL low mid-stretch: exit without updating last_stretch
        scl_req = 1'b0; cyc(12);
        scl_req = 1'b1; slave_hold = 1'b1; cyc(40);
        rd(1, d); check("redrive_stretching", d, 32'h1);
        scl_req = 1'b0; cyc(2);
        rd(1, d); check("redrive_exit", d, 32'h0);
        slave_hold = 1'b0; cyc(20);
        rd(2, d); check("redrive_keep", d, TO);

        // Asynchronous reset mid-stretch
        scl_req = 1'b1; cyc(12);
        sda_low = 1'b1; cyc(10);
        scl_req = 1'b0; cyc(12);
        scl_req = 1'b1; slave_hold = 1'b1; cyc(30);
        rd(1, d); check("pre_reset_flags", d, 32'h15);
        scl_req = 1'b0; cyc(1);
        check("pre_reset_scl_oe", scl_oe, 1'b1);
        #2 reset_n = 1'b0; #1;
        check("async_rst_scl_oe", scl_oe, 1'b0);
        check("async_rst_sda_oe", sda_oe, 1'b0);
        rd(1, d); check("in_reset_addr1", d, 32'h0);
        rd(2, d); check("in_reset_addr2", d, 32'h0);
        scl_req = 1'b1; slave_hold = 1'b0; sda_low = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        cyc(10);
        rd(1, d); check("post_reset_addr1", d, 32'h0);
        rd(2, d); check("post_reset_addr2", d, 32'h0);
        rd(0, d); check("post_reset_addr0", d, 32'h3);

        // Writes to non-W1C addresses are ignored
        wr(3, 32'hFFFF_FFFF);
        rd(3, d); check("addr3_zero", d, 32'h0);
        wr(0, 32'hFFFF_FFFF);
        rd(0, d); check("addr0_ro", d, 32'h3);
        wr(2, 32'hFFFF_FFFF);
        rd(2, d); check("addr2_ro", d, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
